// File: rtl/xor_pkg.sv
// Shared types and helpers for the XOR stream feeder.
package xor_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    OUT
  } state_t;

  // Rotate left by one bit; the per-word key step.
  function automatic logic [DATA_W-1:0] rotl1(input logic [DATA_W-1:0] v);
    return {v[DATA_W-2:0], v[DATA_W-1]};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with combinational read port (dout shows the head entry).
module sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // A push into a full FIFO is legal when the head leaves on the same edge.
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign full      = (r_count == (AW+1)'(DEPTH));
  assign empty     = (r_count == '0);
  assign dout      = r_mem[r_rd_ptr];

  // Storage array; contents need no reset, the count guards every read.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/xor_stream_feeder.sv
// Sequencer that feeds buffered words to an XOR encryptor with a rolling key
// and returns the ciphertext on a valid/ready stream, with a done watchdog.
module xor_stream_feeder
  import xor_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic              key_load,
  input  logic [DATA_W-1:0] key_seed,
  output logic              enc_start,
  output logic [DATA_W-1:0] enc_data,
  output logic [DATA_W-1:0] enc_key,
  input  logic [DATA_W-1:0] enc_data_out,
  input  logic              enc_done,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  state_t            r_state;
  logic [DATA_W-1:0] r_seed;
  logic [DATA_W-1:0] r_cur_key;
  logic [DATA_W-1:0] r_enc_data;
  logic [DATA_W-1:0] r_enc_key;
  logic              r_enc_start;
  logic              r_last;
  logic [TW-1:0]     r_timer;
  logic              r_err;
  logic              r_m_valid;
  logic [DATA_W-1:0] r_m_data;
  logic              r_m_last;

  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [DATA_W:0]   w_dout;

  assign w_push = s_valid && !w_full;
  // The FSM takes the head word only from IDLE and never after a timeout.
  assign w_pop  = (r_state == IDLE) && !w_empty && !r_err;

  sync_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .din   ({s_last, s_data}),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty)
  );

  assign s_ready   = !w_full;
  assign busy      = (r_state != IDLE) || !w_empty;
  assign err       = r_err;
  assign enc_start = r_enc_start;
  assign enc_data  = r_enc_data;
  assign enc_key   = r_enc_key;
  assign m_valid   = r_m_valid;
  assign m_data    = r_m_data;
  assign m_last    = r_m_last;

  // Control FSM, key schedule and watchdog with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_seed      <= '0;
      r_cur_key   <= '0;
      r_enc_data  <= '0;
      r_enc_key   <= '0;
      r_enc_start <= 1'b0;
      r_last      <= 1'b0;
      r_timer     <= '0;
      r_err       <= 1'b0;
      r_m_valid   <= 1'b0;
      r_m_data    <= '0;
      r_m_last    <= 1'b0;
    end else begin
      // Seed loads only when nothing is queued or in flight.
      if (key_load && (r_state == IDLE) && w_empty) begin
        r_seed    <= key_seed;
        r_cur_key <= key_seed;
      end
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_enc_data  <= w_dout[DATA_W-1:0];
            r_enc_key   <= r_cur_key;
            r_last      <= w_dout[DATA_W];
            r_enc_start <= 1'b1;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          r_enc_start <= 1'b0;
          r_timer     <= '0;
          r_state     <= WAIT;
        end
        WAIT: begin
          if (enc_done) begin
            r_m_data  <= enc_data_out;
            r_m_last  <= r_last;
            r_m_valid <= 1'b1;
            r_cur_key <= r_last ? r_seed : rotl1(r_cur_key);
            r_state   <= OUT;
          end else if (r_timer == TMAX) begin
            // Encryptor never answered: drop the word and stop issuing.
            r_err   <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        OUT: begin
          if (m_ready) begin
            r_m_valid <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xor_stream_feeder.sv
// Bench for xor_stream_feeder: behavioural encryptor (with a never-done stub
// mode), random stimulus, key-schedule reference model and output scoreboard.
module tb_xor_stream_feeder;

  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 8;

  logic        clk;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        s_last;
  logic        key_load;
  logic [31:0] key_seed;
  logic        enc_start;
  logic [31:0] enc_data;
  logic [31:0] enc_key;
  logic [31:0] enc_data_out;
  logic        enc_done;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;
  logic        busy;
  logic        err;

  logic        stub_mode;
  logic        enc_busy;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] ref_seed;
  int          ref_idx;
  int          total = 0;
  int          bad   = 0;
  int          start_cnt = 0;

  xor_stream_feeder #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_last       (s_last),
    .key_load     (key_load),
    .key_seed     (key_seed),
    .enc_start    (enc_start),
    .enc_data     (enc_data),
    .enc_key      (enc_key),
    .enc_data_out (enc_data_out),
    .enc_done     (enc_done),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_last       (m_last),
    .busy         (busy),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Encryptor: samples start, answers one cycle later unless in stub mode.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_busy     <= 1'b0;
      enc_done     <= 1'b0;
      enc_data_out <= '0;
    end else begin
      enc_done <= 1'b0;
      if (enc_busy) begin
        enc_busy <= 1'b0;
        if (!stub_mode) begin
          enc_done     <= 1'b1;
          enc_data_out <= enc_data ^ enc_key;
        end
      end else if (enc_start) begin
        enc_busy <= 1'b1;
      end
    end
  end

  always @(negedge clk) if (enc_start) start_cnt++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Key for the n-th word of a packet is the seed rotated left n times.
  function automatic logic [31:0] rotl_n(input logic [31:0] v, input int n);
    int k;
    k = n % 32;
    if (k == 0) return v;
    return (v << k) | (v >> (32 - k));
  endfunction

  // Scoreboard monitor: compare every accepted output word.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_output", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_m_data", m_data, e.data);
        chk("sb_m_last", {31'd0, m_last}, {31'd0, e.last});
      end
    end
  end

  task automatic push_word(input logic [31:0] d, input logic l);
    int   g;
    exp_t e;
    g = 0;
    @(negedge clk);
    while (!s_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (!s_ready) begin
      chk("push_timeout", 32'd0, 32'd1);
    end else begin
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      e.data  = d ^ rotl_n(ref_seed, ref_idx);
      e.last  = l;
      sb_q.push_back(e);
      ref_idx = l ? 0 : ref_idx + 1;
    end
  endtask

  task automatic load_key(input logic [31:0] s);
    @(negedge clk);
    key_load = 1'b1;
    key_seed = s;
    @(posedge clk);
    #1;
    key_load = 1'b0;
    ref_seed = s;
    ref_idx  = 0;
  endtask

  task automatic wait_mvalid(input string nm, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!m_valid && n < 60);
    if (!m_valid) chk({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input string nm);
    int g;
    g = 0;
    @(negedge clk);
    while ((busy || m_valid) && g < 300) begin
      @(negedge clk);
      g++;
    end
    chk({nm, "_idle"}, {31'd0, busy || m_valid}, 32'd0);
  endtask

  task automatic wait_start(input string nm);
    int g;
    g = 0;
    do begin
      @(posedge clk);
      #1;
      g++;
    end while (!enc_start && g < 20);
    chk({nm, "_start_seen"}, {31'd0, enc_start}, 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    int sc;
    rst_n     = 1'b1;
    s_valid   = 1'b0;
    s_data    = '0;
    s_last    = 1'b0;
    key_load  = 1'b0;
    key_seed  = '0;
    m_ready   = 1'b1;
    stub_mode = 1'b0;
    ref_seed  = '0;
    ref_idx   = 0;
    #2 rst_n = 1'b0;
    #20;
    chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_enc_start", {31'd0, enc_start}, 32'd0);
    chk("rst_m_data", m_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single word, latency and known result, then packet end and key rewind.
    load_key(32'h12345678);
    push_word(32'hdeadbeef, 1'b0);
    wait_mvalid("t1", n);
    chk("t1_latency", n, 32'd4);
    chk("t1_data", m_data, 32'hcc99e897);
    push_word(32'h01234567, 1'b1);
    wait_mvalid("t2", n);
    chk("t2_data", m_data, 32'h254be997);
    chk("t2_last", {31'd0, m_last}, 32'd1);
    push_word(32'hdeadbeef, 1'b0);
    wait_mvalid("t3", n);
    chk("t3_rewound", m_data, 32'hcc99e897);
    wait_idle("t3");

    // Backpressure: output holds, FIFO fills.
    load_key(32'habcdef01);
    m_ready = 1'b0;
    push_word(32'h01234567, 1'b0);
    wait_mvalid("bp", n);
    chk("bp_data", m_data, 32'haaeeaa66);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_valid", {31'd0, m_valid}, 32'd1);
      chk("bp_hold_data", m_data, 32'haaeeaa66);
    end
    for (int i = 0; i < FIFO_DEPTH; i++) push_word($urandom, 1'($urandom_range(0, 1)));
    @(negedge clk);
    chk("bp_full_s_ready", {31'd0, s_ready}, 32'd0);
    chk("bp_full_busy", {31'd0, busy}, 32'd1);
    chk("bp_still_data", m_data, 32'haaeeaa66);
    m_ready = 1'b1;
    wait_idle("bp");

    // Burst of six: in order, one result every five cycles.
    load_key($urandom);
    fork
      begin
        for (int i = 0; i < 6; i++) push_word($urandom, 1'b0);
      end
      begin
        int gap;
        wait_mvalid("burst_first", gap);
        for (int i = 1; i < 6; i++) begin
          wait_mvalid("burst", gap);
          chk("burst_spacing", gap, 32'd5);
        end
      end
    join
    wait_idle("burst");

    // Encryptor never answers: watchdog fires, issuing stops.
    stub_mode = 1'b1;
    load_key($urandom);
    push_word($urandom, 1'b0);
    wait_start("to");
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!err && n < 30);
    chk("to_err_cycle", n, TIMEOUT + 1);
    chk("to_err", {31'd0, err}, 32'd1);
    sb_q.delete();
    sc = start_cnt;
    push_word($urandom, 1'b0);
    push_word($urandom, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    chk("to_no_start", start_cnt, sc);
    chk("to_busy", {31'd0, busy}, 32'd1);
    chk("to_err_sticky", {31'd0, err}, 32'd1);
    chk("to_s_ready_room", {31'd0, s_ready}, 32'd1);
    push_word($urandom, 1'b0);
    push_word($urandom, 1'b0);
    @(negedge clk);
    chk("to_s_ready_full", {31'd0, s_ready}, 32'd0);
    chk("to_no_start2", start_cnt, sc);
    sb_q.delete();

    // Asynchronous reset while waiting on the encryptor.
    @(negedge clk);
    rst_n = 1'b0;
    #3;
    stub_mode = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    load_key(32'h0badf00d);
    push_word($urandom, 1'b0);
    wait_start("ar");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_m_valid", {31'd0, m_valid}, 32'd0);
    chk("ar_s_ready", {31'd0, s_ready}, 32'd1);
    chk("ar_busy", {31'd0, busy}, 32'd0);
    chk("ar_err", {31'd0, err}, 32'd0);
    chk("ar_enc_key", enc_key, 32'd0);
    chk("ar_enc_data", enc_data, 32'd0);
    sb_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    load_key(32'h5a5a0f0f);
    push_word(32'h11111111, 1'b1);
    wait_mvalid("ar_after", n);
    chk("ar_after_data", m_data, 32'h4b4b1e1e);
    push_word($urandom, 1'b0);
    wait_idle("final");
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xor_stream_feeder.md
Name: xor_stream_feeder

Overview:
Upstream sequencer for xor_encryptor. It accepts a valid/ready word stream into a small input FIFO and derives a per-word rolling key from a loaded seed. For each word it drives the encryptor's start/data_in/key_in pulse protocol, captures data_out on done, and presents the results on a valid/ready output stream. A watchdog flags an encryptor that never returns done.

Parameters:
- FIFO_DEPTH, 4, input FIFO entries; power of two, ≥2.
- TIMEOUT, 8, max cycles spent in WAIT before an error is raised.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  input word valid.
- s_ready  out  1  FIFO not full.
- s_data  in  32  plaintext word.
- s_last  in  1  last word of packet; the key rewinds to the seed after it.
- key_load  in  1  load key_seed; accepted only when state==IDLE and the FIFO is empty, otherwise ignored.
- key_seed  in  32  base key.
- enc_start  out  1  one-cycle start pulse to the encryptor.
- enc_data  out  32  to encryptor data_in; held stable from start through done.
- enc_key  out  32  to encryptor key_in; held stable from start through done.
- enc_data_out  in  32  encryptor result.
- enc_done  in  1  encryptor done; one-cycle pulse.
- m_valid  out  1  ciphertext valid.
- m_ready  in  1  downstream ready.
- m_data  out  32  ciphertext.
- m_last  out  1  carries the s_last of that word.
- busy  out  1  state!=IDLE or FIFO non-empty.
- err  out  1  sticky timeout flag; cleared only by reset.

Behaviour:
Reset:
- All outputs are 0 except s_ready=1.
- FIFO empty; key registers (seed, cur_key) = 0; state=IDLE.
- Reset is asynchronous and may assert mid-operation. Everything clears and in-flight words are dropped. The encryptor shares rst_n.

Input FIFO:
- Push when s_valid&&s_ready; each entry stores {s_last, s_data}.
- s_ready = !full.
- Push and pop on the same edge are allowed when the FIFO is full; the count is unchanged.
- Pointers wrap modulo FIFO_DEPTH.

Key schedule:
- key_load sets seed=cur_key=key_seed.
- After each word's result is captured: if its last bit was set, cur_key=seed; otherwise cur_key=rotl1(cur_key).

FSM:
- IDLE: if the FIFO is non-empty and err==0, pop the FIFO. Register enc_data=word, enc_key=cur_key, enc_start=1, latch last. Go to ISSUE.
- ISSUE: enc_start=0, clear the timer. Go to WAIT.
- WAIT:
  - On enc_done: m_data=enc_data_out, m_last=latched last, m_valid=1, update cur_key, go to OUT.
  - Otherwise increment the timer. When the timer reaches TIMEOUT, set err=1 and go to IDLE; the word is dropped.
- OUT: hold m_valid/m_data/m_last until m_ready. On the handshake edge, m_valid=0 and go to IDLE.

Encryptor timing contract:
- Start is sampled at the edge after ISSUE is entered.
- enc_done appears 1 cycle later.
- The next start is never issued before the encryptor has returned to IDLE, which OUT→IDLE guarantees.

Latency and throughput:
- Push edge E0 → enc_start high after E1 → m_valid high after E4.
- With m_ready=1, throughput is 1 word per 5 cycles.

Other rules:
- enc_done outside WAIT is ignored.
- While err=1, no further pops occur. The FIFO keeps accepting words until full.

Decomposition:
- Package xor_pkg: DATA_W=32; state enum {IDLE, ISSUE, WAIT, OUT}; rotl1 function.
- Sub-module sync_fifo: parameterised width and depth; ports push, pop, din, dout, full, empty. Reusable.
- The FSM, key schedule and watchdog stay in xor_stream_feeder.
- Bench instantiates xor_stream_feeder + xor_encryptor, plus a stub encryptor that never asserts done for the timeout test.

Test Plan:
- Seed 0x12345678; one word 0xdeadbeef with s_last=0 → m_data=0xcc99e897, m_valid rises 4 cycles after the push edge.
- Continue with 0x01234567, s_last=1 → key 0x2468acf0, m_data=0x254be997, m_last=1. A third word 0xdeadbeef → 0xcc99e897 (key rewound).
- Seed 0xabcdef01; word 0x01234567 → 0xaaeeaa66. Hold m_ready=0 for 10 cycles → m_valid/m_data stay stable, FIFO fills, s_ready=0 after 4 further pushes.
- Burst of 6 words with m_ready=1 → outputs in order, one every 5 cycles, keys seed, rotl1, rotl2, … per word.
- Stub encryptor that never asserts done → err=1 on the cycle after TIMEOUT expires in WAIT. No further enc_start pulses; busy stays 1 while the FIFO is non-empty.
- rst_n low during WAIT → all outputs reset immediately (asynchronous), FIFO empty. After release, a new seed plus word produces the correct result.
